// File: rtl/alu_seq_pkg.sv
// Shared types and the op-code to ALU control-word decode table for alu_sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SLT = 3'd2
  } op_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       c0;
    logic       c1;
    logic       a_mux;
    logic [1:0] b_mux;
    logic       cin;
    logic       sub;
    logic       stl;
    logic [1:0] mux3;
  } ctrl_t;

  // SUB builds on the ADD word and SLT on the SUB word; unlisted codes drive an all-zero word.
  function automatic ctrl_t decode_op(input logic [2:0] code);
    ctrl_t w;
    w = '0;
    case (code)
      OP_ADD, OP_SUB, OP_SLT: begin
        w.c0    = 1'b1;
        w.c1    = 1'b1;
        w.a_mux = 1'b1;
        w.b_mux = 2'b11;
      end
      default: w = '0;
    endcase
    if (code == OP_SUB || code == OP_SLT) begin
      w.sub = 1'b1;
      w.cin = 1'b1;
    end
    if (code == OP_SLT) w.stl = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/alu_sequencer_counter.sv
// Down-counter timer: clear reloads LOAD, enable decrements, terminal flags zero.
module seq_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LOAD  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) count_d = LOAD;
    else if (enable && (count_q != '0)) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= LOAD;
    else        count_q <= count_d;
  end

  assign count    = count_q;
  assign terminal = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per request against the slow instFlag cycle marker.
//   state | meaning
//   IDLE  | ready for a request, all ALU-side outputs zero
//   ARM   | operands/control latched, waiting for an instFlag rise
//   RUN   | A_Fclkpos high, ALU_O_Fclkpos after OUT_DELAY, waiting for next rise
//   DONE  | result presented until res_ready
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int OUT_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instFlag,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [15:0] op_pc,
  input  logic [15:0] op_instr,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] PC_in,
  output logic [15:0] instr_in,
  output logic        ALU_Control0,
  output logic        ALU_Control1,
  output logic        A_mux,
  output logic        B_mux0,
  output logic        B_mux1,
  output logic        Adder_Cin,
  output logic        SUB,
  output logic        STL,
  output logic        mux3_0,
  output logic        mux3_1,
  output logic        A_Fclkpos,
  output logic        ALU_O_Fclkpos,
  input  logic [15:0] alu_out,
  input  logic        out_Zero_Detect,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zero,
  output logic        timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Counter holds TIMEOUT-1-k in the k-th cycle of a state, so zero marks the last allowed cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OUT_CMP  = CNT_W'(TIMEOUT - OUT_DELAY);

  state_e      state_q, state_d;
  logic        inst_flag_q;
  logic        flag_rise, accept, abort, going_idle;
  logic [CNT_W-1:0] count;
  logic        terminal, cnt_clear;

  logic        op_ready_q, op_ready_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [15:0] a_q, a_d, b_q, b_d, pc_q, pc_d, instr_q, instr_d;
  logic        a_fclk_q, a_fclk_d, alu_o_fclk_q, alu_o_fclk_d;
  logic        res_valid_q, res_valid_d, res_zero_q, res_zero_d;
  logic [15:0] res_data_q, res_data_d;
  logic        timeout_err_q, timeout_err_d;

  assign flag_rise = instFlag & ~inst_flag_q;
  assign accept    = op_valid & op_ready_q;
  assign cnt_clear = (state_d != state_q) || !((state_q == S_ARM) || (state_q == S_RUN));

  seq_counter #(.WIDTH(CNT_W), .LOAD(CNT_LOAD)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (1'b1),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      inst_flag_q   <= 1'b0;
      op_ready_q    <= 1'b0;
      ctrl_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      instr_q       <= '0;
      a_fclk_q      <= 1'b0;
      alu_o_fclk_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_flag_q   <= instFlag;
      op_ready_q    <= op_ready_d;
      ctrl_q        <= ctrl_d;
      a_q           <= a_d;
      b_q           <= b_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      a_fclk_q      <= a_fclk_d;
      alu_o_fclk_q  <= alu_o_fclk_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ARM;
      S_ARM: begin
        if (flag_rise) state_d = S_RUN;
        else if (terminal) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end
      end
      S_RUN: begin
        if (flag_rise) state_d = S_DONE;
        else if (terminal) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    going_idle    = (state_d == S_IDLE);
    // Held low during the abort pulse so a new request is only taken after it.
    op_ready_d    = going_idle & ~abort;
    timeout_err_d = abort;
    ctrl_d        = ctrl_q;
    a_d           = a_q;
    b_d           = b_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    if (accept) begin
      ctrl_d  = decode_op(op_code);
      a_d     = op_a;
      b_d     = op_b;
      pc_d    = op_pc;
      instr_d = op_instr;
    end else if (going_idle) begin
      ctrl_d  = '0;
      a_d     = '0;
      b_d     = '0;
      pc_d    = '0;
      instr_d = '0;
    end
    a_fclk_d     = (state_d == S_RUN);
    alu_o_fclk_d = (state_d == S_RUN) &&
                   (alu_o_fclk_q || ((state_q == S_RUN) && (count == OUT_CMP)));
    res_valid_d  = (state_d == S_DONE);
    res_data_d   = res_data_q;
    res_zero_d   = res_zero_q;
    if ((state_q == S_RUN) && flag_rise) begin
      res_data_d = alu_out;
      res_zero_d = out_Zero_Detect;
    end else if (going_idle) begin
      res_data_d = '0;
      res_zero_d = 1'b0;
    end
  end

  assign op_ready      = op_ready_q;
  assign a             = a_q;
  assign b             = b_q;
  assign PC_in         = pc_q;
  assign instr_in      = instr_q;
  assign ALU_Control0  = ctrl_q.c0;
  assign ALU_Control1  = ctrl_q.c1;
  assign A_mux         = ctrl_q.a_mux;
  assign B_mux0        = ctrl_q.b_mux[0];
  assign B_mux1        = ctrl_q.b_mux[1];
  assign Adder_Cin     = ctrl_q.cin;
  assign SUB           = ctrl_q.sub;
  assign STL           = ctrl_q.stl;
  assign mux3_0        = ctrl_q.mux3[0];
  assign mux3_1        = ctrl_q.mux3[1];
  assign A_Fclkpos     = a_fclk_q;
  assign ALU_O_Fclkpos = alu_o_fclk_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_zero      = res_zero_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with a phase-level reference model.
module tb_alu_sequencer;

  localparam int TIMEOUT   = 255;
  localparam int OUT_DELAY = 4;

  logic        clk = 1'b0;
  logic        reset, instFlag, op_valid, op_ready;
  logic [2:0]  op_code;
  logic [15:0] op_a, op_b, op_pc, op_instr;
  logic [15:0] a, b, PC_in, instr_in;
  logic        ALU_Control0, ALU_Control1, A_mux, B_mux0, B_mux1, Adder_Cin, SUB, STL, mux3_0, mux3_1;
  logic        A_Fclkpos, ALU_O_Fclkpos;
  logic [15:0] alu_out;
  logic        out_Zero_Detect;
  logic        res_valid, res_ready, res_zero, timeout_err;
  logic [15:0] res_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT(TIMEOUT), .OUT_DELAY(OUT_DELAY)) dut (
    .clk(clk), .reset(reset), .instFlag(instFlag), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_pc(op_pc), .op_instr(op_instr),
    .a(a), .b(b), .PC_in(PC_in), .instr_in(instr_in),
    .ALU_Control0(ALU_Control0), .ALU_Control1(ALU_Control1), .A_mux(A_mux),
    .B_mux0(B_mux0), .B_mux1(B_mux1), .Adder_Cin(Adder_Cin), .SUB(SUB), .STL(STL),
    .mux3_0(mux3_0), .mux3_1(mux3_1), .A_Fclkpos(A_Fclkpos), .ALU_O_Fclkpos(ALU_O_Fclkpos),
    .alu_out(alu_out), .out_Zero_Detect(out_Zero_Detect), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {op_ready, control word, a, b, PC_in, instr_in, A_F, ALU_O, res_valid, res_data, res_zero, timeout_err}
  function automatic logic [95:0] snap();
    return {op_ready, ALU_Control0, ALU_Control1, A_mux, B_mux1, B_mux0, Adder_Cin, SUB, STL,
            mux3_1, mux3_0, a, b, PC_in, instr_in, A_Fclkpos, ALU_O_Fclkpos, res_valid,
            res_data, res_zero, timeout_err};
  endfunction

  // Control word {C0,C1,A_mux,B_mux1,B_mux0,Cin,SUB,STL,mux3_1,mux3_0}.
  function automatic logic [9:0] exp_ctrl(input logic [2:0] code);
    logic [9:0] w;
    w = 10'b0;
    if (code <= 3'd2) w = 10'b11111_00000;
    if (code == 3'd1 || code == 3'd2) w = w | 10'b00000_11000;
    if (code == 3'd2) w = w | 10'b00000_00100;
    return w;
  endfunction

  function automatic logic [15:0] alu_model(input logic [2:0] code, input logic [15:0] x, input logic [15:0] y);
    case (code)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: return x ^ y;
    endcase
  endfunction

  // One full operation; requires run_wait >= 1, and arm_wait >= 1 when edge_with_accept.
  task automatic do_op(input logic [2:0] code, input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] vpc, input logic [15:0] vins, input int arm_wait,
                       input int run_wait, input int done_wait, input bit edge_with_accept,
                       input bit hold_valid);
    logic [15:0] res;
    logic        rz;
    logic [9:0]  ew;
    logic [95:0] exp_v, obs;
    res = alu_model(code, va, vb);
    rz  = (res == 16'd0);
    ew  = exp_ctrl(code);
    op_code = code; op_a = va; op_b = vb; op_pc = vpc; op_instr = vins;
    op_valid = 1'b1;
    if (edge_with_accept) instFlag = 1'b1;
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL offer_ready: op_ready=%b expected 1", op_ready);
    end
    step();
    if (!hold_valid) op_valid = 1'b0;
    op_code = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    op_pc = 16'($urandom); op_instr = 16'($urandom);
    for (int i = 0; i <= arm_wait; i++) begin
      exp_v = {1'b0, ew, va, vb, vpc, vins, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0};
      obs = snap();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL arm_hold[%0d]: got %h expected %h", i, obs, exp_v);
      end
      if (i == 0 && edge_with_accept) instFlag = 1'b0;
      if (i == arm_wait) instFlag = 1'b1;
      step();
    end
    alu_out = res;
    out_Zero_Detect = rz;
    for (int k = 0; k <= run_wait; k++) begin
      exp_v = {1'b0, ew, va, vb, vpc, vins, 1'b1, (k >= OUT_DELAY), 1'b0, 16'h0, 1'b0, 1'b0};
      obs = snap();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL run_phase[%0d]: got %h expected %h", k, obs, exp_v);
      end
      if (k == 0) instFlag = 1'b0;
      if (k == run_wait) instFlag = 1'b1;
      step();
    end
    instFlag = 1'b0;
    alu_out = 16'($urandom);
    out_Zero_Detect = ~rz;
    for (int j = 0; j <= done_wait; j++) begin
      exp_v = {1'b0, ew, va, vb, vpc, vins, 2'b00, 1'b1, res, rz, 1'b0};
      obs = snap();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL done_hold[%0d]: got %h expected %h", j, obs, exp_v);
      end
      if (j == 0) op_valid = 1'b0;
      if (j == 1) instFlag = 1'b1;
      if (j == 2) instFlag = 1'b0;
      if (j == done_wait) res_ready = 1'b1;
      step();
    end
    res_ready = 1'b0;
    instFlag = 1'b0;
    exp_v = {1'b1, 95'b0};
    obs = snap();
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL idle_after_done: got %h expected %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_reset();
    logic [95:0] obs;
    reset = 1'b0;
    repeat (3) step();
    obs = snap();
    n_cmp++;
    if (obs !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_zero: got %h expected 0", obs);
    end
    reset = 1'b1;
    step();
    obs = snap();
    n_cmp++;
    if (obs !== {1'b1, 95'b0}) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h", obs, {1'b1, 95'b0});
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 16'd1, 16'd2, 16'h0100, 16'hABCD, 0, 5, 1, 1'b0, 1'b0);   // ADD 1+2, ALU_O pulses
    do_op(3'd1, 16'd5, 16'd5, 16'h0102, 16'h1234, 2, 6, 3, 1'b0, 1'b0);   // SUB to zero
    do_op(3'd2, 16'hFFFF, 16'd1, 16'h0104, 16'h5555, 1, 2, 0, 1'b0, 1'b0); // SLT signed
    do_op(3'd0, 16'h7FFF, 16'd1, 16'h0106, 16'h0F0F, 3, 1, 2, 1'b1, 1'b1); // edge with accept
    do_op(3'd1, 16'd9, 16'd3, 16'h0108, 16'h0000, 0, OUT_DELAY - 1, 0, 1'b0, 1'b0);
    do_op(3'd6, 16'hAAAA, 16'h5555, 16'h010A, 16'h00FF, 1, 4, 1, 1'b0, 1'b0); // reserved code
  endtask

  task automatic test_timeout_boundary();
    // Edge on the last cycle before abort must still start RUN.
    do_op(3'd0, 16'd40, 16'd2, 16'h0200, 16'h2222, TIMEOUT - 2, 3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [9:0]  ew;
    logic [15:0] va, vb, vpc, vins;
    logic [95:0] exp_v, obs;
    va = 16'($urandom); vb = 16'($urandom); vpc = 16'($urandom); vins = 16'($urandom);
    ew = exp_ctrl(3'd2);
    op_code = 3'd2; op_a = va; op_b = vb; op_pc = vpc; op_instr = vins;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    for (int s = 0; s < TIMEOUT; s++) begin
      exp_v = {1'b0, ew, va, vb, vpc, vins, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0};
      obs = snap();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL timeout_wait[%0d]: got %h expected %h", s, obs, exp_v);
      end
      step();
    end
    obs = snap();
    n_cmp++;
    if (obs !== 96'b1) begin
      n_bad++;
      $display("FAIL timeout_pulse: got %h expected %h", obs, 96'b1);
    end
    step();
    obs = snap();
    n_cmp++;
    if (obs !== {1'b1, 95'b0}) begin
      n_bad++;
      $display("FAIL timeout_recover: got %h expected %h", obs, {1'b1, 95'b0});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [95:0] obs;
    op_code = 3'd0; op_a = 16'd7; op_b = 16'd8; op_pc = 16'h0300; op_instr = 16'h3333;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    instFlag = 1'b1;
    step();
    instFlag = 1'b0;
    n_cmp++;
    if (A_Fclkpos !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_run_entry: A_Fclkpos=%b expected 1", A_Fclkpos);
    end
    step();
    step();
    reset = 1'b0;
    step();
    obs = snap();
    n_cmp++;
    if (obs !== 96'b0) begin
      n_bad++;
      $display("FAIL mid_run_reset: got %h expected 0", obs);
    end
    reset = 1'b1;
    step();
    obs = snap();
    n_cmp++;
    if (obs !== {1'b1, 95'b0}) begin
      n_bad++;
      $display("FAIL mid_run_release: got %h expected %h", obs, {1'b1, 95'b0});
    end
  endtask

  task automatic test_random_ops();
    logic [2:0] code;
    int aw, rw, dw;
    bit ewa, hv;
    for (int n = 0; n < 24; n++) begin
      code = 3'($urandom_range(0, 7));
      ewa  = 1'($urandom_range(0, 1));
      hv   = 1'($urandom_range(0, 1));
      aw   = $urandom_range(ewa ? 1 : 0, 5);
      rw   = $urandom_range(1, 8);
      dw   = $urandom_range(0, 3);
      do_op(code, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), aw, rw, dw, ewa, hv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; instFlag = 1'b0; op_valid = 1'b0; op_code = 3'd0;
    op_a = 16'h0; op_b = 16'h0; op_pc = 16'h0; op_instr = 16'h0;
    alu_out = 16'h0; out_Zero_Detect = 1'b0; res_ready = 1'b0;
    test_reset();
    test_directed();
    test_timeout_boundary();
    test_timeout();
    test_reset_mid_run();
    test_random_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
